// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Lets the core data port and the DMA external port share one single-port
//   DRAM with synchronous reads. A request is granted in the same cycle it is
//   made, and the granted requester's address, write data and write-enable
//   are steered to the DRAM. Read data is shared on rdata, and a one-cycle-late
//   valid goes only to the requester that issued the read. Run limits on
//   consecutive grants keep either side from starving the other.
//
// Ports
//   clk, rst                      clock (rising edge), async active-low reset
//   core_req/we/addr/din          core access request (held until granted)
//   core_gnt                      core granted this cycle (combinational)
//   core_rvalid                   rdata holds the core read result
//   dma_req/we/addr/din           DMA access request
//   dma_gnt                       DMA granted this cycle (combinational)
//   dma_rvalid                    rdata holds the DMA read result
//   rdata                         shared read data (mem_do pass-through)
//   mem_we/mem_addr/mem_di        DRAM command
//   mem_do                        DRAM read data, one cycle after address
module dram_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int DMA_RUN  = 4,
  parameter int CORE_RUN = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_din,
  output logic          core_gnt,
  output logic          core_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_din,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_do
);

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_CORE,
    OWN_DMA
  } owner_t;

  localparam logic [3:0] DMA_LIM  = 4'(DMA_RUN);
  localparam logic [3:0] CORE_LIM = 4'(CORE_RUN);

  owner_t     owner_q, owner_d;
  logic [3:0] run_q, run_d;
  logic [3:0] run_inc;

  // State register: owner, run length and the read-return valids.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= OWN_IDLE;
      run_q       <= '0;
      core_rvalid <= 1'b0;
      dma_rvalid  <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      run_q       <= run_d;
      core_rvalid <= core_gnt & ~core_we;
      dma_rvalid  <= dma_gnt & ~dma_we;
    end
  end

  assign run_inc = (run_q == '1) ? run_q : run_q + 4'd1;

  // Next state: the owner follows this cycle's grant; a repeat grant to the
  // same owner extends the run, a change of owner starts a new run at 1.
  always_comb begin
    owner_d = OWN_IDLE;
    run_d   = '0;
    if (core_gnt) begin
      owner_d = OWN_CORE;
      run_d   = (owner_q == OWN_CORE) ? run_inc : 4'd1;
    end else if (dma_gnt) begin
      owner_d = OWN_DMA;
      run_d   = (owner_q == OWN_DMA) ? run_inc : 4'd1;
    end
  end

  // Outputs: grant decision and DRAM steering. Reset forces no grant, so
  // the DRAM sees no write while rst is low whatever the requesters do.
  always_comb begin
    core_gnt = 1'b0;
    dma_gnt  = 1'b0;
    if (rst) begin
      if (core_req && dma_req) begin
        // Contention: DMA keeps the port until its run limit, and takes it
        // from the core once the core has used up its run; otherwise core.
        if ((owner_q == OWN_DMA  && run_q <  DMA_LIM) ||
            (owner_q == OWN_CORE && run_q >= CORE_LIM))
          dma_gnt = 1'b1;
        else
          core_gnt = 1'b1;
      end else if (core_req) begin
        core_gnt = 1'b1;
      end else if (dma_req) begin
        dma_gnt = 1'b1;
      end
    end

    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;
    if (core_gnt) begin
      mem_we   = core_we;
      mem_addr = core_addr;
      mem_di   = core_din;
    end else if (dma_gnt) begin
      mem_we   = dma_we;
      mem_addr = dma_addr;
      mem_di   = dma_din;
    end
  end

  assign rdata = mem_do;

endmodule
